// File: rtl/msj_scan_pkg.sv
// Shared scan-state encoding, frame field positions and the frame acceptance check
// used by the MSJ angle scan scheduler.
package msj_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCAN_NEXT = 3'd1,
    ST_SETUP     = 3'd2,
    ST_WAIT      = 3'd3,
    ST_HOLD      = 3'd4,
    ST_FINISH    = 3'd5
  } scan_state_t;

  localparam int ANGLE_W      = 12;
  localparam int FRAME_W      = 16;
  localparam int ERR_FLAG_BIT = 12;

  // A frame is usable only with odd parity across all bits and the sensor error flag clear.
  function automatic logic frame_valid(input logic [FRAME_W-1:0] frame);
    return (^frame) && !frame[ERR_FLAG_BIT];
  endfunction

endpackage

// File: rtl/msj_period_ticker.sv
// Free-running period counter; tick is high in the last count of each period.
// Counter is held at zero while enable is low, so the first tick lands PERIOD-1 clocks after enable.
module msj_period_ticker #(
  parameter int PERIOD = 50_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/msj_angle_scan_scheduler.sv
// Walks enabled angle-sensor slots once per update period over a shared SPI master,
// publishing checked angles with a one-cycle per-slot strobe and sticky error/overrun flags.
module msj_angle_scan_scheduler
  import msj_scan_pkg::*;
#(
  parameter int NUMBER_OF_SENSORS = 6,
  parameter int CLOCK_SPEED_HZ    = 50_000_000,
  parameter int UPDATE_FREQ_HZ    = 1000,
  parameter int CS_SETUP_CYCLES   = 4,
  parameter int CS_HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic                                   enable,
  input  logic [NUMBER_OF_SENSORS-1:0]           sensor_mask,
  input  logic                                   clear_errors,
  output logic                                   spi_start,
  input  logic                                   spi_done,
  input  logic [FRAME_W-1:0]                     spi_rx_data,
  output logic [NUMBER_OF_SENSORS-1:0]           ss_n_o,
  output logic [ANGLE_W*NUMBER_OF_SENSORS-1:0]   angle_o,
  output logic [NUMBER_OF_SENSORS-1:0]           cycle_o,
  output logic [NUMBER_OF_SENSORS-1:0]           sensor_error_o,
  output logic                                   overrun_o,
  output logic                                   scan_done_o,
  output logic                                   busy_o
);

  localparam int NS      = NUMBER_OF_SENSORS;
  localparam int PERIOD  = CLOCK_SPEED_HZ / UPDATE_FREQ_HZ;
  localparam int SLOT_W  = $clog2(NS + 1);
  localparam int MAX_SH  = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > MAX_SH) ? TIMEOUT_CYCLES : MAX_SH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  scan_state_t         state;
  logic [SLOT_W-1:0]   slot;
  logic [CNT_W-1:0]    cnt;
  logic [FRAME_W-1:0]  rx_frame;
  logic                chk_pend;
  logic                tick;
  logic [NS-1:0]       sel;
  logic [NS-1:0]       err_set;
  logic                ovr_set;

  msj_period_ticker #(.PERIOD(PERIOD)) u_ticker (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (tick)
  );

  // One-hot of the current slot; all zeros once slot has walked past the last sensor.
  assign sel         = NS'(1) << slot;
  assign busy_o      = (state != ST_IDLE) && (state != ST_FINISH);
  assign scan_done_o = (state == ST_FINISH);
  assign ovr_set     = tick && busy_o;

  always_comb begin
    err_set = '0;
    if (state == ST_WAIT && !spi_done && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) err_set = sel;
    if (chk_pend && !frame_valid(rx_frame)) err_set = sel;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sensor_error_o <= '0;
      overrun_o      <= 1'b0;
    end else begin
      sensor_error_o <= (clear_errors ? '0 : sensor_error_o) | err_set;
      overrun_o      <= (clear_errors ? 1'b0 : overrun_o) | ovr_set;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      slot      <= '0;
      cnt       <= '0;
      rx_frame  <= '0;
      chk_pend  <= 1'b0;
      spi_start <= 1'b0;
      ss_n_o    <= '1;
      angle_o   <= '0;
      cycle_o   <= '0;
    end else begin
      spi_start <= 1'b0;
      cycle_o   <= '0;
      chk_pend  <= 1'b0;

      if (chk_pend && frame_valid(rx_frame)) begin
        cycle_o <= sel;
        for (int k = 0; k < NS; k++) begin
          if (sel[k]) angle_o[k*ANGLE_W +: ANGLE_W] <= rx_frame[ANGLE_W-1:0];
        end
      end

      case (state)
        ST_IDLE: begin
          if (tick) begin
            state <= ST_SCAN_NEXT;
            slot  <= '0;
          end
        end
        ST_SCAN_NEXT: begin
          if (slot == SLOT_W'(NS)) begin
            state <= ST_FINISH;
          end else if ((sensor_mask & sel) == '0) begin
            slot <= slot + SLOT_W'(1);
          end else begin
            ss_n_o <= ~sel;
            cnt    <= '0;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == CNT_W'(CS_SETUP_CYCLES - 1)) begin
            spi_start <= 1'b1;
            cnt       <= '0;
            state     <= ST_WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          // The completing cycle already counts as the first hold clock.
          if (spi_done) begin
            rx_frame <= spi_rx_data;
            chk_pend <= 1'b1;
            cnt      <= CNT_W'(1);
            state    <= ST_HOLD;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cnt   <= CNT_W'(1);
            state <= ST_HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt >= CNT_W'(CS_HOLD_CYCLES - 1)) begin
            ss_n_o <= '1;
            slot   <= slot + SLOT_W'(1);
            state  <= ST_SCAN_NEXT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_FINISH: begin
          // A tick landing on the finish cycle starts the next scan rather than being lost.
          if (tick) begin
            state <= ST_SCAN_NEXT;
            slot  <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msj_angle_scan_scheduler.sv
// Directed bench: small update period, SPI responder model, per-scan monitor of strobes and chip selects.
module tb_msj_angle_scan_scheduler;
  import msj_scan_pkg::*;

  localparam int NS      = 6;
  localparam int P       = 2000;
  localparam int SPI_LAT = 2;
  localparam int SETUP   = 4;
  localparam int HOLD    = 4;
  localparam int TMO     = 1024;

  logic                  clock;
  logic                  reset_n;
  logic                  enable;
  logic [NS-1:0]         sensor_mask;
  logic                  clear_errors;
  logic                  spi_start;
  logic                  spi_done;
  logic [15:0]           spi_rx_data;
  logic [NS-1:0]         ss_n_o;
  logic [12*NS-1:0]      angle_o;
  logic [NS-1:0]         cycle_o;
  logic [NS-1:0]         sensor_error_o;
  logic                  overrun_o;
  logic                  scan_done_o;
  logic                  busy_o;

  msj_angle_scan_scheduler #(
    .NUMBER_OF_SENSORS (NS),
    .CLOCK_SPEED_HZ    (50_000_000),
    .UPDATE_FREQ_HZ    (25_000),
    .CS_SETUP_CYCLES   (SETUP),
    .CS_HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .sensor_mask    (sensor_mask),
    .clear_errors   (clear_errors),
    .spi_start      (spi_start),
    .spi_done       (spi_done),
    .spi_rx_data    (spi_rx_data),
    .ss_n_o         (ss_n_o),
    .angle_o        (angle_o),
    .cycle_o        (cycle_o),
    .sensor_error_o (sensor_error_o),
    .overrun_o      (overrun_o),
    .scan_done_o    (scan_done_o),
    .busy_o         (busy_o)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] resp [NS];
  bit          silent [NS];
  logic [11:0] am [NS];

  int strobe_cnt [NS];
  int sel_cnt [NS];
  int ord_bad, multi_low, min_low, max_low, low_run, last_strobe;
  int overlap_bad = 0;
  bit scan_open = 0;
  bit busy_q = 0;
  logic [NS-1:0] ss_q = '1;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mk_frame(input logic [11:0] ang, input bit flag, input bit good);
    logic [15:0] f;
    f = {3'b000, flag, ang};
    if ((^f) != good) f[15] = ~f[15];
    return f;
  endfunction

  function automatic logic [12*NS-1:0] pack_am();
    logic [12*NS-1:0] v;
    for (int k = 0; k < NS; k++) v[k*12 +: 12] = am[k];
    return v;
  endfunction

  function automatic logic [NS-1:0] strobe_vec();
    logic [NS-1:0] v;
    for (int k = 0; k < NS; k++) v[k] = (strobe_cnt[k] == 1);
    return v;
  endfunction

  function automatic logic [NS-1:0] sel_vec();
    logic [NS-1:0] v;
    for (int k = 0; k < NS; k++) v[k] = (sel_cnt[k] != 0);
    return v;
  endfunction

  // SPI responder: answers spi_start with spi_done SPI_LAT clocks later unless the slot is silent.
  initial begin
    int s;
    spi_done    = 0;
    spi_rx_data = '0;
    forever begin
      @(negedge clock);
      if (spi_start && reset_n) begin
        s = 0;
        for (int k = 0; k < NS; k++) if (!ss_n_o[k]) s = k;
        if (!silent[s]) begin
          repeat (SPI_LAT) @(negedge clock);
          spi_done    = 1;
          spi_rx_data = resp[s];
          @(negedge clock);
          spi_done    = 0;
        end
      end
    end
  end

  // Per-scan statistics, restarted whenever busy_o rises.
  initial begin
    forever begin
      @(negedge clock);
      if (busy_o && !busy_q) begin
        if (scan_open) overlap_bad++;
        scan_open = 1;
        for (int k = 0; k < NS; k++) begin
          strobe_cnt[k] = 0;
          sel_cnt[k]    = 0;
        end
        ord_bad = 0; multi_low = 0; min_low = 1_000_000; max_low = 0; last_strobe = -1;
      end
      if (scan_done_o || !reset_n) scan_open = 0;
      busy_q = busy_o;
      for (int k = 0; k < NS; k++) begin
        if (cycle_o[k]) begin
          strobe_cnt[k]++;
          if (k <= last_strobe) ord_bad++;
          last_strobe = k;
        end
        if (ss_q[k] && !ss_n_o[k]) sel_cnt[k]++;
      end
      if ($countones(~ss_n_o) > 1) multi_low++;
      if (ss_n_o != '1) begin
        low_run++;
      end else if (low_run != 0) begin
        if (low_run < min_low) min_low = low_run;
        if (low_run > max_low) max_low = low_run;
        low_run = 0;
      end
      ss_q = ss_n_o;
    end
  end

  // kind 0: busy_o high, 1: scan_done_o high, 2: ss_n_o equals tgt. cyc counts clocks waited.
  task automatic wait_cond(input string tag, input int kind, input logic [NS-1:0] tgt,
                           input int max, output int cyc);
    bit hit = 0;
    cyc = 0;
    while (!hit && cyc < max) begin
      @(negedge clock);
      cyc++;
      case (kind)
        0:       hit = busy_o;
        1:       hit = scan_done_o;
        default: hit = (ss_n_o == tgt);
      endcase
    end
    chk({tag, "_reached"}, hit, 1'b1);
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clear_errors = 1;
    @(negedge clock);
    clear_errors = 0;
    @(negedge clock);
  endtask

  initial begin
    int cyc;
    low_run = 0;
    reset_n = 0; enable = 0; clear_errors = 0;
    sensor_mask = 6'b101010;
    for (int k = 0; k < NS; k++) begin
      resp[k]   = mk_frame(12'(12'h100 + k), 1'b0, 1'b1);
      silent[k] = 0;
      am[k]     = '0;
    end
    repeat (3) @(negedge clock);

    chk("rst_ss_n", ss_n_o, 6'h3F);
    chk("rst_angle", angle_o, '0);
    chk("rst_cycle", cycle_o, '0);
    chk("rst_err", sensor_error_o, '0);
    chk("rst_flags", {overrun_o, scan_done_o, busy_o, spi_start}, 4'b0000);

    enable = 1; reset_n = 1;
    wait_cond("first_tick", 0, '0, 3 * P, cyc);
    chk("first_tick_lat", cyc, P);

    // Partial mask from reset: only odd slots touched.
    wait_cond("scanA", 1, '0, P, cyc);
    @(negedge clock);
    am[1] = 12'h101; am[3] = 12'h103; am[5] = 12'h105;
    chk("A_angle", angle_o, pack_am());
    chk("A_strobe", strobe_vec(), 6'b101010);
    chk("A_sel", sel_vec(), 6'b101010);

    // Full mask, two consecutive scans one period apart.
    sensor_mask = 6'h3F;
    wait_cond("scanB", 1, '0, 2 * P, cyc);
    wait_cond("scanC", 1, '0, 2 * P, cyc);
    chk("scan_interval", cyc, P);
    @(negedge clock);
    for (int k = 0; k < NS; k++) am[k] = 12'(12'h100 + k);
    chk("C_angle", angle_o, pack_am());
    chk("C_strobe", strobe_vec(), 6'h3F);
    chk("C_order", ord_bad, 0);
    chk("C_multi_low", multi_low, 0);
    chk("C_min_low", min_low, SETUP + SPI_LAT + HOLD);
    chk("C_max_low", max_low, SETUP + SPI_LAT + HOLD);

    // All slots masked: busy rises one clock after tick, done NS+2 clocks after tick.
    sensor_mask = '0;
    wait_cond("mask0_start", 0, '0, 2 * P, cyc);
    wait_cond("mask0_done", 1, '0, P, cyc);
    chk("mask0_lat", cyc, NS + 1);
    @(negedge clock);
    chk("mask0_sel", sel_vec(), '0);
    chk("mask0_angle", angle_o, pack_am());

    // Flag-set frame on slot 2, even parity on slot 4.
    sensor_mask = 6'h3F;
    for (int k = 0; k < NS; k++) resp[k] = mk_frame(12'(12'h300 + k), 1'b0, 1'b1);
    resp[2] = 16'h1ABC;
    resp[4] = mk_frame(12'h777, 1'b0, 1'b0);
    wait_cond("err_start", 0, '0, 2 * P, cyc);
    wait_cond("err_done", 1, '0, P, cyc);
    @(negedge clock);
    am[0] = 12'h300; am[1] = 12'h301; am[3] = 12'h303; am[5] = 12'h305;
    chk("err_flags", sensor_error_o, 6'b010100);
    chk("err_strobe", strobe_vec(), 6'b101011);
    chk("err_angle", angle_o, pack_am());
    pulse_clear();
    chk("err_cleared", sensor_error_o, '0);

    // Slot 3 never answers.
    for (int k = 0; k < NS; k++) resp[k] = mk_frame(12'(12'h400 + k), 1'b0, 1'b1);
    silent[3] = 1;
    wait_cond("tmo_start", 0, '0, 2 * P, cyc);
    wait_cond("tmo_done", 1, '0, P, cyc);
    @(negedge clock);
    am[0] = 12'h400; am[1] = 12'h401; am[2] = 12'h402; am[4] = 12'h404; am[5] = 12'h405;
    chk("tmo_flags", sensor_error_o, 6'b001000);
    chk("tmo_strobe", strobe_vec(), 6'b110111);
    chk("tmo_angle", angle_o, pack_am());
    chk("tmo_low", max_low, SETUP + (TMO - 1) + HOLD);
    chk("tmo_ss_idle", ss_n_o, 6'h3F);
    pulse_clear();

    // Two silent slots stretch the scan past one period.
    silent[1] = 1;
    wait_cond("ovr_start", 0, '0, 2 * P, cyc);
    wait_cond("ovr_done", 1, '0, 2 * P, cyc);
    silent[1] = 0; silent[3] = 0;
    @(negedge clock);
    chk("ovr_flag", overrun_o, 1'b1);
    chk("ovr_errs", sensor_error_o, 6'b001010);
    chk("ovr_overlap", overlap_bad, 0);
    chk("ovr_angle", angle_o, pack_am());
    pulse_clear();
    chk("ovr_cleared", {overrun_o, sensor_error_o}, 7'd0);

    // Reset while waiting on slot 1.
    silent[1] = 1;
    wait_cond("rst_sel1", 2, 6'b111101, 3 * P, cyc);
    repeat (20) @(negedge clock);
    chk("mid_in_wait", ss_n_o, 6'b111101);
    reset_n = 0;
    #1;
    chk("mid_rst_ss_n", ss_n_o, 6'h3F);
    chk("mid_rst_angle", angle_o, '0);
    chk("mid_rst_flags", {busy_o, spi_start, scan_done_o, overrun_o, cycle_o, sensor_error_o}, '0);
    @(negedge clock);
    silent[1] = 0;
    reset_n = 1;
    wait_cond("post_rst_tick", 0, '0, 3 * P, cyc);
    chk("post_rst_lat", cyc, P);
    wait_cond("post_rst_done", 1, '0, P, cyc);
    @(negedge clock);
    for (int k = 0; k < NS; k++) am[k] = 12'(12'h400 + k);
    chk("post_rst_angle", angle_o, pack_am());
    chk("post_rst_strobe", strobe_vec(), 6'h3F);
    chk("post_rst_err", sensor_error_o, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
